// File: rtl/rvc_pkg.sv
// Shared definitions for the srf access path: controller states, default widths
// and the index of the hardwired-zero register.
package rvc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int X0_ADDR    = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } srf_state_t;

endpackage

// File: rtl/rf_req_fifo.sv
// Two-entry synchronous request FIFO holding {wr, addr, wdata}.
// The head entry is presented combinationally so the controller can pop it
// and decide the next state in the same cycle.
module rf_req_fifo
    import rvc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ADDR_W+DATA_W:0]     din,
    input  logic                       pop,
    output logic [ADDR_W+DATA_W:0]     dout,
    output logic                       full,
    output logic                       empty
);

    localparam int ENTRY_W = ADDR_W + DATA_W + 1;

    logic [ENTRY_W-1:0] mem_reg [2];
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [1:0]         count_reg;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == 2'd2);
    assign empty   = (count_reg == 2'd0);
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem_reg[rd_ptr_reg];

    // Storage array: no reset needed, contents are qualified by count_reg.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/srf_access_ctrl.sv
// Initiator side of the srf register-file handshake. Requests are buffered in a
// two-entry FIFO and sequenced one at a time onto srf; x0 accesses are answered
// locally and a missing srf_done is converted into an error response.
module srf_access_ctrl
    import rvc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              srf_en,
    output logic              srf_wr,
    output logic [ADDR_W-1:0] srf_add,
    output logic [DATA_W-1:0] srf_datain,
    input  logic [DATA_W-1:0] srf_dataout,
    input  logic              srf_done,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    srf_state_t state_reg, state_next;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W+DATA_W:0] fifo_dout;
    logic              fifo_wr;
    logic [ADDR_W-1:0] fifo_addr;
    logic [DATA_W-1:0] fifo_wdata;

    logic              hold_wr_reg;
    logic [ADDR_W-1:0] hold_addr_reg;
    logic [DATA_W-1:0] hold_wdata_reg;

    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic              rsp_err_reg, rsp_err_next;
    logic              access_phase;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    // The head is taken only while the engine is idle: one srf access in flight.
    assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;
    assign {fifo_wr, fifo_addr, fifo_wdata} = fifo_dout;

    rf_req_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   ({req_wr, req_addr, req_wdata}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Hold registers capture the popped request for the duration of the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_wr_reg    <= 1'b0;
            hold_addr_reg  <= '0;
            hold_wdata_reg <= '0;
        end else if (fifo_pop) begin
            hold_wr_reg    <= fifo_wr;
            hold_addr_reg  <= fifo_addr;
            hold_wdata_reg <= fifo_wdata;
        end
    end

    // State, timeout counter and response payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    // Next-state logic; the response payload is latched on entry to RESP and held.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (fifo_addr == ADDR_W'(X0_ADDR)) begin
                        // x0 never touches srf: reads return zero, writes vanish.
                        state_next     = ST_RESP;
                        rsp_rdata_next = '0;
                        rsp_err_next   = 1'b0;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (srf_done) begin
                    state_next     = ST_RESP;
                    rsp_rdata_next = hold_wr_reg ? '0 : srf_dataout;
                    rsp_err_next   = 1'b0;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (srf_done) begin
                    // A done arriving on the last permitted cycle still counts as success.
                    state_next     = ST_RESP;
                    rsp_rdata_next = hold_wr_reg ? '0 : srf_dataout;
                    rsp_err_next   = 1'b0;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    state_next     = ST_RESP;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // srf address/data are driven only while an access is outstanding.
    assign access_phase = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
    assign srf_en       = (state_reg == ST_ISSUE);
    assign srf_wr       = access_phase && hold_wr_reg;
    assign srf_add      = access_phase ? hold_addr_reg  : '0;
    assign srf_datain   = access_phase ? hold_wdata_reg : '0;

    assign rsp_valid    = (state_reg == ST_RESP);
    assign rsp_rdata    = rsp_valid ? rsp_rdata_reg : '0;
    assign rsp_err      = rsp_valid && rsp_err_reg;
    assign busy         = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_srf_access_ctrl.sv
// Bench for srf_access_ctrl: a behavioural srf responder with programmable done
// delay, an in-order response scoreboard fed by a register-file model, a table of
// directed single transactions with latency checks, and randomized traffic.
module tb_srf_access_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int TO    = 15;
    localparam int NEVER = 99;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          srf_en;
    logic          srf_wr;
    logic [AW-1:0] srf_add;
    logic [DW-1:0] srf_datain;
    logic [DW-1:0] srf_dataout;
    logic          srf_done;
    logic          busy;

    always #5 clk = ~clk;

    srf_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .srf_en      (srf_en),
        .srf_wr      (srf_wr),
        .srf_add     (srf_add),
        .srf_datain  (srf_datain),
        .srf_dataout (srf_dataout),
        .srf_done    (srf_done),
        .busy        (busy)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            dly;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;
        int            exp_en;
    } vec_t;

    int            checks   = 0;
    int            failures = 0;
    rsp_t          exp_q[$];
    int            delay_q[$];
    logic [DW-1:0] shadow  [32];
    logic [DW-1:0] srf_mem [32];
    int            en_count = 0;
    logic          last_wr;
    logic [AW-1:0] last_add;
    logic [DW-1:0] last_data;
    logic          random_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Reference model: responses follow request order; srf performs the write when
    // it sees the strobe, so a timed-out write still lands in the register file.
    task automatic model_push(input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input int dly);
        rsp_t r;
        r.err   = (a != 0) && (dly > TO);
        r.rdata = (!wr && a != 0 && !r.err) ? shadow[a] : '0;
        if (a != 0) delay_q.push_back(dly);
        if (wr && a != 0) shadow[a] = d;
        exp_q.push_back(r);
        $display("req wr=%0d addr=%0d wdata=0x%08h dly=%0d -> exp rdata=0x%08h err=%0d",
                 wr, a, d, dly, r.rdata, r.err);
    endtask

    // Offer one request (call at posedge+1); returns at posedge+1 after acceptance.
    task automatic offer(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int dly);
        logic acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!acc) fail_now("offer_timeout");
        else model_push(wr, a, d, dly);
    endtask

    // srf stand-in: answers each strobe after the delay queued for that access.
    initial begin
        int            cd;
        logic          prev_en;
        logic [DW-1:0] rd_val;
        int            d;
        cd          = -1;
        prev_en     = 1'b0;
        rd_val      = '0;
        srf_done    = 1'b0;
        srf_dataout = '0;
        forever begin
            @(negedge clk);
            srf_done    = 1'b0;
            srf_dataout = $urandom;
            if (rst) begin
                cd      = -1;
                prev_en = 1'b0;
            end else begin
                if (srf_en) begin
                    check("srf_en_width", prev_en, 1'b0);
                    check("srf_en_not_x0", srf_add != 0, 1'b1);
                    en_count++;
                    last_wr   = srf_wr;
                    last_add  = srf_add;
                    last_data = srf_datain;
                    rd_val    = srf_mem[srf_add];
                    if (srf_wr) srf_mem[srf_add] = srf_datain;
                    if (delay_q.size() == 0) begin
                        fail_now("unexpected_srf_en");
                        cd = 0;
                    end else begin
                        d  = delay_q.pop_front();
                        cd = (d > TO) ? -1 : d;
                    end
                end else if (cd > 0) begin
                    check("wait_add_stable", srf_add, last_add);
                    check("wait_wr_stable", srf_wr, last_wr);
                    check("wait_datain_stable", srf_datain, last_data);
                    cd--;
                end
                if (cd == 0) begin
                    srf_done    = 1'b1;
                    srf_dataout = last_wr ? DW'($urandom) : rd_val;
                    cd          = -1;
                end
                prev_en = srf_en;
            end
        end
    end

    // Response monitor: in-order scoreboard plus payload stability while stalled.
    initial begin
        logic          stalled;
        logic [DW-1:0] pr;
        logic          pe;
        rsp_t          r;
        stalled = 1'b0;
        pr      = '0;
        pe      = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !rsp_valid) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_rdata_stable", rsp_rdata, pr);
                    check("stall_err_stable", rsp_err, pe);
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_response");
                    end else begin
                        r = exp_q.pop_front();
                        $display("rsp rdata=0x%08h err=%0d (exp 0x%08h %0d)",
                                 rsp_rdata, rsp_err, r.rdata, r.err);
                        check("rsp_rdata", rsp_rdata, r.rdata);
                        check("rsp_err", rsp_err, r.err);
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pr      = rsp_rdata;
                    pe      = rsp_err;
                end
            end
        end
    end

    // Random response backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (random_ready) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        vec_t          vecs [8];
        int            n;
        int            en0;
        int            idx;
        int            accepted;
        logic          got;
        logic          acc;
        logic [DW-1:0] got_rdata;
        logic          got_err;
        vec_t          bp [4];

        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 0,     32'h0,        1'b0, 3,  1};
        vecs[1] = '{1'b0, 5'd5, 32'h0,        0,     32'hDEADBEEF, 1'b0, 3,  1};
        vecs[2] = '{1'b1, 5'd0, 32'h00001234, 0,     32'h0,        1'b0, 2,  0};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        0,     32'h0,        1'b0, 2,  0};
        vecs[4] = '{1'b0, 5'd3, 32'h0,        NEVER, 32'h0,        1'b1, 18, 1};
        vecs[5] = '{1'b1, 5'd3, 32'h00000055, 4,     32'h0,        1'b0, 7,  1};
        vecs[6] = '{1'b0, 5'd3, 32'h0,        TO,    32'h00000055, 1'b0, 18, 1};
        vecs[7] = '{1'b0, 5'd3, 32'h0,        0,     32'h00000055, 1'b0, 3,  1};

        bp[0] = '{1'b1, 5'd9,  32'hA5A5A5A5, 0, 32'h0, 1'b0, 0, 0};
        bp[1] = '{1'b0, 5'd9,  32'h0,        0, 32'h0, 1'b0, 0, 0};
        bp[2] = '{1'b1, 5'd10, 32'h0BADF00D, 0, 32'h0, 1'b0, 0, 0};
        bp[3] = '{1'b0, 5'd10, 32'h0,        0, 32'h0, 1'b0, 0, 0};

        for (int i = 0; i < 32; i++) begin
            shadow[i]  = '0;
            srf_mem[i] = '0;
        end
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_srf_en", srf_en, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_req_ready", req_ready, 1'b1);
        check("post_reset_rsp_rdata", rsp_rdata, '0);
        check("post_reset_rsp_err", rsp_err, 1'b0);
        check("post_reset_srf_add", srf_add, '0);
        @(posedge clk);
        #1;

        // Directed single transactions with latency from the accepting edge.
        for (int i = 0; i < 8; i++) begin
            en0 = en_count;
            offer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].dly);
            n         = 0;
            got       = 1'b0;
            got_rdata = '0;
            got_err   = 1'b0;
            while (n < 40 && !got) begin
                n++;
                @(negedge clk);
                if (rsp_valid) begin
                    got       = 1'b1;
                    got_rdata = rsp_rdata;
                    got_err   = rsp_err;
                end
                @(posedge clk);
            end
            #1;
            $display("vec %0d: lat=%0d rdata=0x%08h err=%0d srf_en_pulses=%0d",
                     i, n, got_rdata, got_err, en_count - en0);
            check("vec_got_response", got, 1'b1);
            check("vec_latency", n, vecs[i].exp_lat);
            check("vec_rdata", got_rdata, vecs[i].exp_rdata);
            check("vec_err", got_err, vecs[i].exp_err);
            check("vec_srf_en_count", en_count - en0, vecs[i].exp_en);
            if (vecs[i].exp_en != 0) begin
                check("vec_srf_add", last_add, vecs[i].addr);
                check("vec_srf_wr", last_wr, vecs[i].wr);
                if (vecs[i].wr) check("vec_srf_datain", last_data, vecs[i].wdata);
            end
        end

        // Backpressure: responses stalled for 10 cycles; only 3 requests fit.
        rsp_ready = 1'b0;
        idx       = 0;
        accepted  = 0;
        repeat (10) begin
            req_valid = (idx < 4);
            if (idx < 4) begin
                req_wr    = bp[idx].wr;
                req_addr  = bp[idx].addr;
                req_wdata = bp[idx].wdata;
            end
            @(negedge clk);
            acc = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                model_push(bp[idx].wr, bp[idx].addr, bp[idx].wdata, bp[idx].dly);
                idx++;
                accepted++;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", accepted, 3);
        check("bp_req_ready_low", req_ready, 1'b0);
        check("bp_rsp_valid", rsp_valid, 1'b1);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        while (idx < 4) begin
            offer(bp[idx].wr, bp[idx].addr, bp[idx].wdata, bp[idx].dly);
            idx++;
        end
        n = 0;
        while (n < 200 && (exp_q.size() != 0 || busy)) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("bp_drained", exp_q.size(), 0);

        // Reset in the middle of a WAIT: the access and its response disappear.
        offer(1'b0, 5'd7, 32'h0, NEVER);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        delay_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_srf_en", srf_en, 1'b0);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_req_ready", req_ready, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        offer(1'b0, 5'd5, 32'h0, 2);

        // Randomized traffic with random backpressure and done delays.
        random_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            int            dsel;
            int            dly;
            logic [AW-1:0] a;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            dsel = $urandom_range(0, 9);
            dly  = (dsel < 4) ? 0 : (dsel < 6) ? $urandom_range(1, 5) :
                   (dsel == 6) ? TO - 1 : (dsel == 7) ? TO : (dsel == 8) ? TO + 1 : NEVER;
            a    = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            offer($urandom_range(0, 1) == 1, a, $urandom, dly);
        end
        n = 0;
        while (n < 3000 && (exp_q.size() != 0 || busy)) begin
            @(posedge clk);
            n++;
        end
        #1;
        random_ready = 1'b0;
        rsp_ready    = 1'b1;
        check("random_drained", exp_q.size(), 0);
        check("random_not_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
